mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Parametrised multi-port front end for the single-port synchronous video/program RAM. It accepts independent read/write requests from `NUM_PORTS` masters (CPU fetch, CPU load/store, VGA scan-out), arbitrates one access per clock, drives the RAM port from registers, and returns read data to the originating port with a per-port valid strobe. It replaces the single-master pass-through memory controller and sits between the masters and the RAM black box.

## Interface
**Parameters**
- `NUM_PORTS`, default 2: number of requesting masters, 1–8.
- `ADDR_WIDTH`, default 24: RAM address width.
- `DATA_WIDTH`, default 16: RAM data width.
- `READ_LATENCY`, default 1: RAM clock-to-dout latency in cycles, 1–4.

**Ports**
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_PORTS  per-port request; held with its payload until granted.
- `we`  in  NUM_PORTS  per-port write (1) / read (0).
- `addr`  in  NUM_PORTS*ADDR_WIDTH  packed addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- `wdata`  in  NUM_PORTS*DATA_WIDTH  packed write data.
- `gnt`  out  NUM_PORTS  one-hot combinational grant; the request is accepted when `req[i] & gnt[i]` at a rising edge.
- `rvalid`  out  NUM_PORTS  one-hot, one-cycle read-data-valid strobe.
- `rdata`  out  DATA_WIDTH  shared read data, qualified by `rvalid`.
- `ram_addr`  out  ADDR_WIDTH  registered RAM address.
- `ram_we`  out  1  registered RAM write enable.
- `ram_din`  out  DATA_WIDTH  registered RAM write data.
- `ram_dout`  in  DATA_WIDTH  RAM read data.

## Operation
- Arbiter: `gnt` is at most one-hot, zero when no `req` is set, and zero while `reset` is high. `gnt[i]` is never asserted without `req[i]`.
- Issue stage: an accepted request loads `ram_addr`, `ram_we`, and `ram_din` on the same edge. In a cycle with no acceptance, `ram_we` loads 0, and `ram_addr`/`ram_din` hold their values.
- Tag pipeline: a shift register of depth READ_LATENCY+1 carries {valid, port index} for each accepted read. Writes insert a bubble.
- Return stage: when the tag reaches the end of the pipeline, `rdata` registers `ram_dout` and `rvalid[port]` pulses for one cycle. `rdata` holds its last value otherwise.
- Ordering: accesses are issued strictly in acceptance order. A write accepted at edge T is visible to any read accepted at T+1 or later. A simultaneous read and write to the same address from different ports are serialised by the arbiter; the loser observes the winner's effect.
- Throughput: one access per cycle. There is no backpressure on read return; masters must accept `rvalid` unconditionally.
- Reset values: `ram_addr`=0, `ram_we`=0, `ram_din`=0, `rdata`=0, `rvalid`=0, all tag valid bits 0, round-robin pointer=0.
- Reset mid-operation: all in-flight reads are discarded and no `rvalid` is produced for them. A write registered on the edge before `reset` still reaches the RAM; `ram_we` clears on the first reset edge.

## Timing
- Request accepted at edge T.
- `ram_*` are valid during cycle T+1.
- `ram_dout` is valid at T+1+READ_LATENCY.
- `rvalid`/`rdata` are valid during cycle T+2+READ_LATENCY. With READ_LATENCY=1, a read returns 3 cycles after acceptance.
- Write completion is signalled by the grant only; there is no separate acknowledge.
- The `gnt` path is combinational from `req` and the pointer. It has no combinational path from `ram_dout`.

## Configuration
- Macro `MEM_PORT_ARBITER_RR_EN`.
- Defined: round-robin arbitration. The pointer is set to (granted index + 1) mod NUM_PORTS on each acceptance. The search starts at the pointer, so no port starves while all hold `req`.
- Undefined: fixed priority, lowest index wins. The pointer register is not implemented. A continuously requesting port 0 starves all others.

## Test plan
- Reset: hold `reset` for 3 cycles with `req`=2'b11 → `gnt`=0, `rvalid`=0, `ram_we`=0, `ram_addr`=0 throughout. First grant appears in the cycle after `reset` drops.
- Write then read, port 0: write 0xBEEF to addr 0x000010 at edge T, then read addr 0x000010 at T+1 → `ram_we`=1 in cycle T+1. `rvalid`=2'b01 with `rdata`=0xBEEF in cycle T+4 (READ_LATENCY=1).
- Contention: both ports hold read requests for 4 cycles → with RR_EN, grants are 01,10,01,10; without it, 01,01,01,01. Each `rvalid` matches its port's address data.
- Back-to-back reads: port 1 reads addresses 0x20, 0x21, 0x22 on consecutive edges → three consecutive `rvalid[1]` pulses in order, with no gaps.
- Same-address collision: port 0 writes 0x1234 and port 1 reads the same address in the same cycle. With RR pointer=0, port 0 wins → port 1, granted next cycle, reads 0x1234.
- Reset mid-flight: assert `reset` one cycle after a read is accepted → no `rvalid` pulse ever appears for that read. `rdata` is 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Multi-port front end for the single-port synchronous RAM: one access per clock, registered RAM port, tagged read return.
// Define MEM_PORT_ARBITER_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module mem_port_arbiter #(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_WIDTH   = 24,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS-1:0]             we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata,
  output logic [NUM_PORTS-1:0]             gnt,
  output logic [NUM_PORTS-1:0]             rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic                             ram_we,
  output logic [DATA_WIDTH-1:0]            ram_din,
  input  logic [DATA_WIDTH-1:0]            ram_dout
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DEPTH = READ_LATENCY + 1;

  logic                   gnt_any;
  logic [IDX_W-1:0]       gnt_idx;
  logic [NUM_PORTS-1:0]   gnt_c;

`ifdef MEM_PORT_ARBITER_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found_hi;
  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    found_hi = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    gnt_any  = 1'b0;
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (req[j]) begin
        gnt_any = 1'b1;
        idx_lo  = IDX_W'(j);
        if (j >= int'(ptr_q)) begin
          found_hi = 1'b1;
          idx_hi   = IDX_W'(j);
        end
      end
    end
    gnt_idx = found_hi ? idx_hi : idx_lo;
    if (reset) gnt_any = 1'b0;
    ptr_d = ptr_q;
    if (gnt_any) begin
      if (gnt_idx == IDX_W'(NUM_PORTS - 1)) ptr_d = '0;
      else                                 ptr_d = gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (req[j]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
    if (reset) gnt_any = 1'b0;
  end
`endif

  always_comb begin
    gnt_c = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      gnt_c[j] = gnt_any && (int'(gnt_idx) == j);
    end
  end

  assign gnt = gnt_c;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_we;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (int'(gnt_idx) == j) begin
        sel_addr  = addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata[j*DATA_WIDTH +: DATA_WIDTH];
        sel_we    = we[j];
      end
    end
  end

  logic [ADDR_WIDTH-1:0]          ram_addr_q, ram_addr_d;
  logic                           ram_we_q, ram_we_d;
  logic [DATA_WIDTH-1:0]          ram_din_q, ram_din_d;
  logic [DEPTH-1:0]               tag_vld_q, tag_vld_d;
  logic [DEPTH-1:0][IDX_W-1:0]    tag_idx_q, tag_idx_d;
  logic [NUM_PORTS-1:0]           rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;

  // Reads carry their port tag down a pipeline matched to the RAM latency; writes leave a bubble.
  always_comb begin
    ram_we_d   = gnt_any & sel_we;
    ram_addr_d = gnt_any ? sel_addr  : ram_addr_q;
    ram_din_d  = gnt_any ? sel_wdata : ram_din_q;

    tag_vld_d    = '0;
    tag_idx_d    = '0;
    tag_vld_d[0] = gnt_any & ~sel_we;
    tag_idx_d[0] = gnt_idx;
    for (int s = 1; s < DEPTH; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end

    rvalid_d = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      rvalid_d[j] = tag_vld_q[DEPTH-1] && (int'(tag_idx_q[DEPTH-1]) == j);
    end
    rdata_d = tag_vld_q[DEPTH-1] ? ram_dout : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_din_q  <= '0;
      tag_vld_q  <= '0;
      tag_idx_q  <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      ram_din_q  <= ram_din_d;
      tag_vld_q  <= tag_vld_d;
      tag_idx_q  <= tag_idx_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_we   = ram_we_q;
  assign ram_din  = ram_din_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, checked cycle by cycle
// against a transaction-level model (reference memory plus a queue of expected read returns).
module tb_mem_port_arbiter;

  localparam int NP = 2;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int RL = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NP-1:0]     req = '0;
  logic [NP-1:0]     we = '0;
  logic [NP*AW-1:0]  addr = '0;
  logic [NP*DW-1:0]  wdata = '0;
  logic [NP-1:0]     gnt;
  logic [NP-1:0]     rvalid;
  logic [DW-1:0]     rdata;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [DW-1:0]     ram_din;
  logic [DW-1:0]     ram_dout;

  mem_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural RAM with RL cycles of clock-to-dout latency.
  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] dpipe [RL];
  logic          ram_init_done = 1'b0;

  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 16'(i * 37 + 5);
      ram_init_done <= 1'b1;
    end else begin
      dpipe[0] <= ram_mem[ram_addr[7:0]];
      for (int i = 1; i < RL; i++) dpipe[i] <= dpipe[i-1];
      if (ram_we === 1'b1) ram_mem[ram_addr[7:0]] <= ram_din;
    end
  end

  assign ram_dout = dpipe[RL-1];

  typedef struct {
    int            due;
    int            port;
    logic [DW-1:0] data;
  } pend_t;

  pend_t          pend[$];
  logic [DW-1:0]  ref_mem [256];
  int             ptr_m = 0;
  int             call_idx = 0;
  bit             model_ok = 0;
  logic [NP-1:0]  exp_rvalid;
  logic [DW-1:0]  exp_rdata;
  logic           exp_ram_we;
  logic [AW-1:0]  exp_ram_addr;
  logic [DW-1:0]  exp_ram_din;
  logic [NP-1:0]  last_gnt;
  int             tests = 0;
  int             fails = 0;

  task automatic checkOutput();
    pend_t e;
    if (!model_ok) return;
    exp_rvalid = '0;
    if (pend.size() > 0 && pend[0].due == call_idx) begin
      e          = pend.pop_front();
      exp_rvalid = 2'(1 << e.port);
      exp_rdata  = e.data;
    end
    tests++;
    assert (rvalid === exp_rvalid) else begin
      fails++;
      $error("[TB] FAIL rvalid step %0d: got %b expected %b", call_idx, rvalid, exp_rvalid);
    end
    tests++;
    assert (rdata === exp_rdata) else begin
      fails++;
      $error("[TB] FAIL rdata step %0d: got %h expected %h", call_idx, rdata, exp_rdata);
    end
    tests++;
    assert (ram_we === exp_ram_we) else begin
      fails++;
      $error("[TB] FAIL ram_we step %0d: got %b expected %b", call_idx, ram_we, exp_ram_we);
    end
    tests++;
    assert (ram_addr === exp_ram_addr) else begin
      fails++;
      $error("[TB] FAIL ram_addr step %0d: got %h expected %h", call_idx, ram_addr, exp_ram_addr);
    end
    tests++;
    assert (ram_din === exp_ram_din) else begin
      fails++;
      $error("[TB] FAIL ram_din step %0d: got %h expected %h", call_idx, ram_din, exp_ram_din);
    end
  endtask

  // One clock cycle: check what the previous edge produced, drive new inputs, check the
  // combinational grant, then advance the model across the coming rising edge.
  task automatic applyStimulus(input logic rst, input logic [NP-1:0] r, input logic [NP-1:0] w,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int            p;
    logic [NP-1:0] eg;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    checkOutput();
    reset = rst;
    req   = r;
    we    = w;
    addr  = {a1, a0};
    wdata = {d1, d0};
    #1;
    p = -1;
    if (!rst) begin
`ifdef MEM_PORT_ARBITER_RR_EN
      for (int k = 0; k < NP; k++) if (p < 0 && r[(ptr_m + k) % NP]) p = (ptr_m + k) % NP;
`else
      for (int k = 0; k < NP; k++) if (p < 0 && r[k]) p = k;
`endif
    end
    eg = (p < 0) ? '0 : NP'(1 << p);
    last_gnt = eg;
    tests++;
    assert (gnt === eg) else begin
      fails++;
      $error("[TB] FAIL gnt step %0d: got %b expected %b", call_idx, gnt, eg);
    end
    if (rst) begin
      pend.delete();
      exp_rdata    = '0;
      exp_ram_we   = 1'b0;
      exp_ram_addr = '0;
      exp_ram_din  = '0;
      ptr_m        = 0;
      model_ok     = 1;
    end else if (p >= 0) begin
      a = (p == 0) ? a0 : a1;
      d = (p == 0) ? d0 : d1;
      exp_ram_addr = a;
      exp_ram_din  = d;
      exp_ram_we   = w[p];
      if (w[p]) ref_mem[a[7:0]] = d;
      else      pend.push_back('{due: call_idx + RL + 2, port: p, data: ref_mem[a[7:0]]});
      ptr_m = (p + 1) % NP;
    end else begin
      exp_ram_we = 1'b0;
    end
    call_idx++;
  endtask

  logic [NP-1:0]  hr;
  logic [NP-1:0]  hw;
  logic [AW-1:0]  ha [NP];
  logic [DW-1:0]  hd [NP];

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 37 + 5);
    exp_rdata = '0;

    // Reset held three cycles with both ports requesting, then release.
    for (int i = 0; i < 3; i++) applyStimulus(1, 2'b11, 2'b00, 24'h1, 24'h2, 16'h0, 16'h0);
    applyStimulus(0, 2'b00, 2'b00, 24'h0, 24'h0, 16'h0, 16'h0);

    // Write then read on port 0.
    applyStimulus(0, 2'b01, 2'b01, 24'h000010, 24'h0, 16'hBEEF, 16'h0);
    applyStimulus(0, 2'b01, 2'b00, 24'h000010, 24'h0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 2'b00, 2'b00, 24'h0, 24'h0, 16'h0, 16'h0);

    // Contention: both ports read for four cycles.
    for (int i = 0; i < 4; i++) applyStimulus(0, 2'b11, 2'b00, 24'h000030, 24'h000040, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 2'b00, 2'b00, 24'h0, 24'h0, 16'h0, 16'h0);

    // Back-to-back reads on port 1.
    for (int i = 0; i < 3; i++) applyStimulus(0, 2'b10, 2'b00, 24'h0, 24'(32 + i), 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 2'b00, 2'b00, 24'h0, 24'h0, 16'h0, 16'h0);

    // Reset mid-flight: read accepted, reset on the following cycle.
    applyStimulus(0, 2'b01, 2'b00, 24'h000021, 24'h0, 16'h0, 16'h0);
    applyStimulus(1, 2'b00, 2'b00, 24'h0, 24'h0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 2'b00, 2'b00, 24'h0, 24'h0, 16'h0, 16'h0);

    // Same-address collision straight after reset (pointer at 0).
    applyStimulus(1, 2'b00, 2'b00, 24'h0, 24'h0, 16'h0, 16'h0);
    applyStimulus(0, 2'b11, 2'b01, 24'h000050, 24'h000050, 16'h1234, 16'h0);
    applyStimulus(0, 2'b10, 2'b00, 24'h0, 24'h000050, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 2'b00, 2'b00, 24'h0, 24'h0, 16'h0, 16'h0);

    // Random traffic; each request is held with its payload until granted.
    hr = '0;
    hw = '0;
    for (int p = 0; p < NP; p++) begin
      ha[p] = '0;
      hd[p] = '0;
    end
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!hr[p] && $urandom_range(0, 9) < 6) begin
          hr[p] = 1'b1;
          hw[p] = ($urandom_range(0, 2) == 0);
          ha[p] = 24'($urandom_range(0, 31));
          hd[p] = 16'($urandom);
        end
      end
      if ($urandom_range(0, 99) == 0) begin
        applyStimulus(1, hr, hw, ha[0], ha[1], hd[0], hd[1]);
      end else begin
        applyStimulus(0, hr, hw, ha[0], ha[1], hd[0], hd[1]);
        hr = hr & ~last_gnt;
      end
    end
    for (int i = 0; i < RL + 4; i++) applyStimulus(0, 2'b00, 2'b00, 24'h0, 24'h0, 16'h0, 16'h0);

    tests++;
    assert (pend.size() == 0) else begin
      fails++;
      $error("[TB] FAIL drain: got %0d outstanding reads expected 0", pend.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
